ahb_burst_addr_gen: RTL

//  Beat-by-beat AHB burst address generator feeding the AHB-to-APB bridge.

---
 rtl/ahb_burst_addr_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_burst_addr_gen.sv
// ahb_burst_addr_gen
//   Generates the address of each beat of an AHB burst for the AHB-to-APB
//   bridge. A burst is loaded on START with a one-hot burst behaviour,
//   a start address and a size. Each ADVANCE then steps the beat address,
//   using INCR or WRAP arithmetic.
//
// Ports
//   HCLK, HRESETn       clock and asynchronous active-low reset
//   START               load a new burst (highest priority)
//   BEHAVIOR[7:0]       one-hot: SINGLE,INCR,WRAP4,INCR4,WRAP8,INCR8,WRAP16,INCR16
//   HADDR_IN, HSIZE_IN  first-beat address and size, sampled with START
//   ADVANCE             current beat completed
//   STOP                master abandoned the burst
//   ADDR_OUT, BEAT_CNT  current beat address and 0-based beat index
//   BURST_ACTIVE        burst in progress
//   LAST_BEAT           current beat is the final beat of a fixed-length burst
//   BEH_ERR             one-cycle pulse after an illegal BEHAVIOR/HSIZE at START
//   BOUND_ERR           one-cycle pulse when an INCR burst would cross 1KB
//
// Configuration
//   AHB_1KB_BOUNDARY_CHECK_EN: when defined, INCR-type bursts stop at a 1KB
//   crossing and pulse BOUND_ERR. When not defined, BOUND_ERR is tied low.
module ahb_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_HSIZE  = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  START,
  input  logic [7:0]            BEHAVIOR,
  input  logic [ADDR_WIDTH-1:0] HADDR_IN,
  input  logic [2:0]            HSIZE_IN,
  input  logic                  ADVANCE,
  input  logic                  STOP,
  output logic [ADDR_WIDTH-1:0] ADDR_OUT,
  output logic [4:0]            BEAT_CNT,
  output logic                  BURST_ACTIVE,
  output logic                  LAST_BEAT,
  output logic                  BEH_ERR,
  output logic                  BOUND_ERR
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  localparam logic [2:0] MAX_SZ = 3'(MAX_HSIZE);

  logic [0:0]            state;
  logic [7:0]            beh_q;
  logic [2:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [4:0]            cnt_q;
  logic                  beh_err_q;

  logic                  beh_ok, size_ok, is_wrap, fixed, last;
  logic [4:0]            last_idx;
  logic [2:0]            wrap_sh;
  logic [ADDR_WIDTH-1:0] bytes, mask, incr, nxt;

  // A non-zero value with a single bit set satisfies x & (x-1) == 0.
  assign beh_ok  = (BEHAVIOR != 8'd0) && ((BEHAVIOR & (BEHAVIOR - 8'd1)) == 8'd0);
  assign size_ok = (HSIZE_IN <= MAX_SZ);

  assign is_wrap = beh_q[2] | beh_q[4] | beh_q[6];
  assign fixed   = ~beh_q[1];

  always_comb begin
    last_idx = 5'd0;
    wrap_sh  = 3'd2;
    case (1'b1)
      beh_q[2], beh_q[3]: begin last_idx = 5'd3;  wrap_sh = 3'd2; end
      beh_q[4], beh_q[5]: begin last_idx = 5'd7;  wrap_sh = 3'd3; end
      beh_q[6], beh_q[7]: begin last_idx = 5'd15; wrap_sh = 3'd4; end
      default:            begin last_idx = 5'd0;  wrap_sh = 3'd2; end
    endcase
  end

  // For WRAPn the wrap window is n*bytes. The low bits increment within the
  // window, and the high bits stay where the burst started.
  assign bytes = ADDR_WIDTH'(1) << size_q;
  assign mask  = (bytes << wrap_sh) - ADDR_WIDTH'(1);
  assign incr  = addr_q + bytes;
  assign nxt   = is_wrap ? ((addr_q & ~mask) | (incr & mask)) : incr;

  assign last  = (state == BURST) && fixed && (cnt_q == last_idx);

`ifdef AHB_1KB_BOUNDARY_CHECK_EN
  logic cross, bound_err_q;
  assign cross = !is_wrap && (incr[ADDR_WIDTH-1:10] != addr_q[ADDR_WIDTH-1:10]);
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      beh_q     <= 8'd0;
      size_q    <= 3'd0;
      addr_q    <= '0;
      cnt_q     <= 5'd0;
      beh_err_q <= 1'b0;
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
      bound_err_q <= 1'b0;
`endif
    end else begin
      beh_err_q <= 1'b0;
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
      bound_err_q <= 1'b0;
`endif
      if (START) begin
        if (!beh_ok || !size_ok) begin
          // A bad START still kills any burst already in flight.
          state     <= IDLE;
          beh_err_q <= 1'b1;
        end else begin
          state  <= BURST;
          beh_q  <= BEHAVIOR;
          size_q <= HSIZE_IN;
          addr_q <= HADDR_IN;
          cnt_q  <= 5'd0;
        end
      end else if (state == BURST) begin
        if (STOP) begin
          state <= IDLE;
        end else if (ADVANCE) begin
          if (last) begin
            state <= IDLE;
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
          end else if (cross) begin
            state       <= IDLE;
            bound_err_q <= 1'b1;
`endif
          end else begin
            // Unbounded INCR lets the 5-bit count wrap 31 -> 0.
            cnt_q  <= cnt_q + 5'd1;
            addr_q <= nxt;
          end
        end
      end
    end
  end

  assign ADDR_OUT     = addr_q;
  assign BEAT_CNT     = cnt_q;
  assign BURST_ACTIVE = (state == BURST);
  assign LAST_BEAT    = last;
  assign BEH_ERR      = beh_err_q;
`ifdef AHB_1KB_BOUNDARY_CHECK_EN
  assign BOUND_ERR    = bound_err_q;
`else
  assign BOUND_ERR    = 1'b0;
`endif

endmodule
